// File: rtl/fmul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// fmul_issue_ctrl : FP multiply issue/reservation controller with tag pipeline
// Revision: 1.0
// ============================================================================
module fmul_issue_ctrl #(
  parameter int LATENCY  = 7,
  parameter int VEC_TAIL = 4,
  parameter int MAX_VL   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_s_req,
  input  logic        i_v_req,
  input  logic [15:0] i_cip,
  input  logic [6:0]  i_vl,
  output logic        o_s_ack,
  output logic        o_v_ack,
  output logic        o_busy,
  output logic        o_fu_issue,
  output logic [15:0] o_fu_cip,
  output logic        o_fu_vec,
  output logic [5:0]  o_elem_idx,
  output logic        o_wb_valid,
  output logic        o_wb_vec,
  output logic [2:0]  o_wb_dest,
  output logic [5:0]  o_wb_elem
);

  localparam logic [6:0] MAX_VL_C  = 7'(MAX_VL);
  localparam logic [2:0] TAIL_LAST = 3'(VEC_TAIL - 1);
  localparam int         TAG_W     = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VRUN  = 2'd1,
    VTAIL = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [6:0]  opcode;
  logic        s_legal, v_legal;
  logic [6:0]  vl_clamped;
  logic [6:0]  vl_eff;
  logic [6:0]  elem_cnt;
  logic [2:0]  tail_cnt;
  logic        s_issue;
  logic        last_elem;
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_q [LATENCY];

  assign opcode     = i_cip[15:9];
  assign s_legal    = (opcode >= 7'o064) && (opcode <= 7'o067);
  assign v_legal    = (opcode >= 7'o160) && (opcode <= 7'o167);
  assign vl_clamped = (i_vl > MAX_VL_C) ? MAX_VL_C : i_vl;
  assign last_elem  = (elem_cnt == vl_eff - 7'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Vector wins a simultaneous request even when its parcel is not a vector op.
  always_comb begin
    state_nxt = state;
    o_s_ack   = 1'b0;
    o_v_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (i_v_req && v_legal) begin
          o_v_ack   = 1'b1;
          state_nxt = (vl_clamped != 7'd0) ? VRUN : VTAIL;
        end else if (i_s_req && !i_v_req && s_legal) begin
          o_s_ack = 1'b1;
        end
      end
      VRUN:    if (last_elem) state_nxt = VTAIL;
      VTAIL:   if (tail_cnt == TAIL_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vl_eff   <= 7'd0;
      elem_cnt <= 7'd0;
      tail_cnt <= 3'd0;
      s_issue  <= 1'b0;
      o_fu_cip <= 16'd0;
    end else begin
      s_issue <= o_s_ack;
      if (o_s_ack || o_v_ack) o_fu_cip <= i_cip;
      if (o_v_ack) begin
        vl_eff   <= vl_clamped;
        elem_cnt <= 7'd0;
        tail_cnt <= 3'd0;
      end else begin
        if (state == VRUN && !last_elem) elem_cnt <= elem_cnt + 7'd1;
        if (state == VTAIL) tail_cnt <= (state_nxt == IDLE) ? 3'd0 : tail_cnt + 3'd1;
      end
    end
  end

  assign o_busy     = (state != IDLE);
  assign o_fu_vec   = (state == VRUN);
  assign o_fu_issue = s_issue | o_fu_vec;
  assign o_elem_idx = o_fu_vec ? elem_cnt[5:0] : 6'd0;

  // Tag layout: {valid, vec, dest[2:0], elem[5:0]}
  assign tag_in = {o_fu_issue, o_fu_vec, o_fu_cip[8:6], o_elem_idx};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign o_wb_valid = tag_q[LATENCY-1][10];
  assign o_wb_vec   = tag_q[LATENCY-1][9];
  assign o_wb_dest  = tag_q[LATENCY-1][8:6];
  assign o_wb_elem  = tag_q[LATENCY-1][5:0];

endmodule
`default_nettype wire

// File: tb/tb_fmul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fmul_issue_ctrl : directed, table-driven bench for fmul_issue_ctrl
// Revision: 1.0
// ============================================================================
module tb_fmul_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_req, v_req;
  logic [15:0] cip;
  logic [6:0]  vl;
  logic        s_ack, v_ack, busy, fu_issue, fu_vec;
  logic [15:0] fu_cip;
  logic [5:0]  elem_idx;
  logic        wb_valid, wb_vec;
  logic [2:0]  wb_dest;
  logic [5:0]  wb_elem;

  int n_cmp = 0;
  int n_err = 0;

  fmul_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .i_s_req(s_req), .i_v_req(v_req), .i_cip(cip), .i_vl(vl),
    .o_s_ack(s_ack), .o_v_ack(v_ack), .o_busy(busy),
    .o_fu_issue(fu_issue), .o_fu_cip(fu_cip), .o_fu_vec(fu_vec), .o_elem_idx(elem_idx),
    .o_wb_valid(wb_valid), .o_wb_vec(wb_vec), .o_wb_dest(wb_dest), .o_wb_elem(wb_elem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       v;
    logic [6:0] op;
    logic       exp_s;
    logic       exp_v;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  function automatic logic [15:0] parcel(input logic [6:0] op, input logic [2:0] i);
    return {op, i, 3'd1, 3'd2};
  endfunction

  task automatic idle_drain(input int n);
    s_req = 0; v_req = 0;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int issues;
    int last_idx;
    logic [15:0] p;

    tbl[0]  = '{1, 0, 7'o064, 1, 0};
    tbl[1]  = '{1, 0, 7'o067, 1, 0};
    tbl[2]  = '{1, 0, 7'o063, 0, 0};
    tbl[3]  = '{1, 0, 7'o070, 0, 0};
    tbl[4]  = '{1, 0, 7'o160, 0, 0};
    tbl[5]  = '{0, 1, 7'o160, 0, 1};
    tbl[6]  = '{0, 1, 7'o167, 0, 1};
    tbl[7]  = '{0, 1, 7'o157, 0, 0};
    tbl[8]  = '{0, 1, 7'o170, 0, 0};
    tbl[9]  = '{0, 1, 7'o064, 0, 0};
    tbl[10] = '{0, 0, 7'o065, 0, 0};
    tbl[11] = '{1, 1, 7'o162, 0, 1};

    rst = 1; s_req = 0; v_req = 0; cip = 16'd0; vl = 7'd0;
    tick(); tick(); tick();
    rst = 0;
    settle();
    chk("reset_busy", busy, 0);
    chk("reset_issue", fu_issue, 0);
    chk("reset_cip", fu_cip, 0);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_elem", elem_idx, 0);
    chk("reset_ack", {s_ack, v_ack}, 0);
    tick();

    // Opcode legality and arbitration table, each entry from a clean reset
    for (int e = 0; e < 12; e++) begin
      p = parcel(tbl[e].op, 3'd5);
      s_req = tbl[e].s; v_req = tbl[e].v; cip = p; vl = 7'd3;
      settle();
      chk($sformatf("tbl%0d_s_ack", e), s_ack, tbl[e].exp_s);
      chk($sformatf("tbl%0d_v_ack", e), v_ack, tbl[e].exp_v);
      tick();
      s_req = 0; v_req = 0;
      settle();
      chk($sformatf("tbl%0d_issue", e), fu_issue, tbl[e].exp_s | tbl[e].exp_v);
      chk($sformatf("tbl%0d_busy", e), busy, tbl[e].exp_v);
      chk($sformatf("tbl%0d_cip", e), fu_cip, (tbl[e].exp_s | tbl[e].exp_v) ? p : 16'd0);
      rst = 1; tick(); rst = 0;
    end
    idle_drain(2);

    // Single scalar: issue at t+1, write-back at t+8, never busy
    s_req = 1; cip = parcel(7'o064, 3'd3);
    settle();
    chk("sc_ack", s_ack, 1);
    chk("sc_busy0", busy, 0);
    tick(); s_req = 0; cip = 16'hFFFF;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) tick();
      settle();
      chk($sformatf("sc_issue_t%0d", k), fu_issue, k == 1);
      chk($sformatf("sc_busy_t%0d", k), busy, 0);
      chk($sformatf("sc_wbv_t%0d", k), wb_valid, k == 8);
      if (k == 8) begin
        chk("sc_wb_dest", wb_dest, 3);
        chk("sc_wb_vec", wb_vec, 0);
        chk("sc_wb_elem", wb_elem, 0);
      end
    end
    idle_drain(2);

    // Vector VL=5, i=2
    v_req = 1; cip = parcel(7'o161, 3'd2); vl = 7'd5;
    settle();
    chk("v5_ack", v_ack, 1);
    tick(); v_req = 0; vl = 7'd9;
    for (int k = 1; k <= 13; k++) begin
      if (k > 1) tick();
      settle();
      chk($sformatf("v5_busy_t%0d", k), busy, k <= 9);
      chk($sformatf("v5_issue_t%0d", k), fu_issue, k <= 5);
      chk($sformatf("v5_fuvec_t%0d", k), fu_vec, k <= 5);
      if (k <= 5) chk($sformatf("v5_idx_t%0d", k), elem_idx, k - 1);
      chk($sformatf("v5_wbv_t%0d", k), wb_valid, (k >= 8) && (k <= 12));
      if (k >= 8 && k <= 12) begin
        chk($sformatf("v5_wbelem_t%0d", k), wb_elem, k - 8);
        chk($sformatf("v5_wbdest_t%0d", k), wb_dest, 2);
        chk($sformatf("v5_wbvec_t%0d", k), wb_vec, 1);
      end
    end
    idle_drain(2);

    // Simultaneous requests: vector wins, scalar acked when busy drops
    s_req = 1; v_req = 1; cip = parcel(7'o163, 3'd1); vl = 7'd2;
    settle();
    chk("sim_v_ack", v_ack, 1);
    chk("sim_s_ack", s_ack, 0);
    tick(); v_req = 0; cip = parcel(7'o065, 3'd5);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) tick();
      settle();
      chk($sformatf("sim_busy_t%0d", k), busy, k <= 6);
      chk($sformatf("sim_sack_t%0d", k), s_ack, k == 7);
    end
    tick(); s_req = 0;
    settle();
    chk("sim_s_issue", fu_issue, 1);
    chk("sim_s_cip", fu_cip, parcel(7'o065, 3'd5));
    idle_drain(10);

    // VL=0: four busy clocks, nothing issued
    v_req = 1; cip = parcel(7'o160, 3'd4); vl = 7'd0;
    settle();
    chk("vl0_ack", v_ack, 1);
    tick(); v_req = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) tick();
      settle();
      chk($sformatf("vl0_busy_t%0d", k), busy, k <= 4);
      chk($sformatf("vl0_issue_t%0d", k), fu_issue, 0);
      chk($sformatf("vl0_wbv_t%0d", k), wb_valid, 0);
    end
    idle_drain(2);

    // VL=100 clamps to 64
    v_req = 1; cip = parcel(7'o166, 3'd6); vl = 7'd100;
    settle();
    chk("vl100_ack", v_ack, 1);
    tick(); v_req = 0;
    issues = 0; last_idx = -1;
    for (int k = 1; k <= 76; k++) begin
      if (k > 1) tick();
      settle();
      if (fu_issue) begin issues++; last_idx = elem_idx; end
      chk($sformatf("vl100_busy_t%0d", k), busy, k <= 68);
      chk($sformatf("vl100_issue_t%0d", k), fu_issue, k <= 64);
      if (k <= 64) chk($sformatf("vl100_idx_t%0d", k), elem_idx, k - 1);
      chk($sformatf("vl100_wbv_t%0d", k), wb_valid, (k >= 8) && (k <= 71));
      if (k >= 8 && k <= 71) chk($sformatf("vl100_wbelem_t%0d", k), wb_elem, k - 8);
    end
    chk("vl100_count", issues, 64);
    chk("vl100_last", last_idx, 63);
    idle_drain(2);

    // Back-to-back scalars keep order
    for (int j = 0; j < 3; j++) begin
      if (j > 0) tick();
      s_req = 1; cip = parcel(7'o066, 3'(4 + j));
      settle();
      chk($sformatf("b2b_ack%0d", j), s_ack, 1);
    end
    tick(); s_req = 0;
    for (int k = 3; k <= 11; k++) begin
      if (k > 3) tick();
      settle();
      chk($sformatf("b2b_wbv_t%0d", k), wb_valid, (k >= 8) && (k <= 10));
      if (k >= 8 && k <= 10) chk($sformatf("b2b_dest_t%0d", k), wb_dest, k - 4);
    end
    idle_drain(2);

    // Reset in the middle of a vector run
    v_req = 1; cip = parcel(7'o164, 3'd7); vl = 7'd10;
    settle();
    chk("mid_ack", v_ack, 1);
    tick(); v_req = 0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick();
      settle();
      chk($sformatf("mid_idx_t%0d", k), elem_idx, k - 1);
    end
    rst = 1;
    tick(); rst = 0;
    settle();
    chk("mid_busy", busy, 0);
    chk("mid_issue", fu_issue, 0);
    chk("mid_cip", fu_cip, 0);
    chk("mid_elem", elem_idx, 0);
    chk("mid_fuvec", fu_vec, 0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      settle();
      chk($sformatf("mid_wbv_%0d", k), wb_valid, 0);
      chk($sformatf("mid_post_issue_%0d", k), fu_issue, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
